// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bundle for the load/store unit.
//   req_*   : one load or store per handshake (req_valid & req_ready)
//   resp_*  : single-cycle response pulse, no backpressure
//   mem_*   : word-addressed, byte-enabled synchronous data memory
// Modports: slave = the load/store unit, master = requester plus memory side.
interface load_store_unit_if #(
  parameter int unsigned ADDRESS_WIDTH = 4
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [31:0]              req_addr;
  logic [31:0]              req_wdata;
  logic                     resp_valid;
  logic [31:0]              resp_rdata;
  logic                     resp_err;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [3:0]               mem_byteEnable;
  logic [31:0]              mem_din;
  logic [31:0]              mem_dout;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_byteEnable, mem_din
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_byteEnable, mem_din
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit for a 32-bit byte-addressable, write-first data memory.
// Decodes RV32I funct3, builds word address, byte enables and lane-aligned store data,
// and sign/zero-extends load data. Illegal funct3 and unsupported misaligned accesses
// return resp_err with rdata 0 and no memory write.
// Optional feature macro: MISALIGNED_SPLIT_EN -- performs misaligned accesses, using a
// second memory access for ones that cross a word boundary.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : load_store_unit_if.slave (req_*, resp_*, mem_* signals)
module load_store_unit #(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);
  localparam int unsigned ByteAddrWidth = ADDRESS_WIDTH + 2;

`ifdef MISALIGNED_SPLIT_EN
  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;
`else
  typedef enum logic [1:0] {StIdle, StAcc0, StResp} state_e;
`endif

  state_e                   state_q, state_d;
  logic                     we_q;
  logic [2:0]               funct3_q;
  logic [ADDRESS_WIDTH-1:0] word_q;
  logic [1:0]               off_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     accept;

  assign accept = bus.req_valid && (state_q == StIdle);

  // Address bits above the memory range are ignored.
  logic unused_addr;
  assign unused_addr = ^bus.req_addr[31:ByteAddrWidth];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      word_q   <= '0;
      off_q    <= 2'b00;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= bus.req_we;
        funct3_q <= bus.req_funct3;
        word_q   <= bus.req_addr[ByteAddrWidth-1:2];
        off_q    <= bus.req_addr[1:0];
        wdata_q  <= bus.req_wdata;
      end
    end
  end

  // Access decode from the registered request.
  logic [3:0] mask;
  logic       illegal;
  logic       misaligned;
  logic       err;
  logic       split;

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

  assign illegal = we_q ? (funct3_q > 3'd2)
                        : ((funct3_q[1:0] == 2'b11) || (funct3_q == 3'b110));
  assign misaligned = ((funct3_q[1:0] == 2'b01) && off_q[0]) ||
                      ((funct3_q[1:0] == 2'b10) && (off_q != 2'b00));

`ifdef MISALIGNED_SPLIT_EN
  logic [2:0] size;
  logic       crossing;
  logic [7:0] be_pair;
  logic [31:0] lo_buf_q, lo_buf_d;

  assign size     = (funct3_q[1:0] == 2'b00) ? 3'd1 : (funct3_q[1:0] == 2'b01) ? 3'd2 : 3'd4;
  assign crossing = ({1'b0, off_q} + size) > 3'd4;
  assign err      = illegal;
  // misaligned is fully serviced in this build; only crossing decides the path
  assign split    = !illegal && crossing && (misaligned || !misaligned);
  // Lower nibble enables word w, upper nibble enables word w+1.
  assign be_pair  = {4'b0000, mask} << off_q;

  always_ff @(posedge clk) begin
    if (rst) lo_buf_q <= '0;
    else     lo_buf_q <= lo_buf_d;
  end
`else
  logic [3:0] be_pair;

  assign err     = illegal || misaligned;
  assign split   = 1'b0;
  assign be_pair = mask << off_q;
`endif

  // Store data rotated so byte i lands in lane (off + i) mod 4.
  assign bus.mem_din = 32'({wdata_q, wdata_q} >> (6'd32 - {1'b0, off_q, 3'b000}));

  // Load data: low word is the first access, high word the (possibly same) second one.
  logic [31:0] lo_word;
  logic [31:0] aligned;
  logic [31:0] ext;

`ifdef MISALIGNED_SPLIT_EN
  assign lo_word = split ? lo_buf_q : bus.mem_dout;
`else
  assign lo_word = bus.mem_dout;
`endif
  assign aligned = 32'({bus.mem_dout, lo_word} >> {off_q, 3'b000});

  always_comb begin
    case (funct3_q)
      3'b000:  ext = {{24{aligned[7]}}, aligned[7:0]};
      3'b001:  ext = {{16{aligned[15]}}, aligned[15:0]};
      3'b100:  ext = {24'h000000, aligned[7:0]};
      3'b101:  ext = {16'h0000, aligned[15:0]};
      default: ext = aligned;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_err       = 1'b0;
    bus.resp_rdata     = 32'h0;
    bus.mem_addr       = word_q;
    bus.mem_byteEnable = 4'b0000;
`ifdef MISALIGNED_SPLIT_EN
    lo_buf_d           = lo_buf_q;
`endif
    case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = StAcc0;
      end
      StAcc0: begin
        if (we_q && !err) bus.mem_byteEnable = be_pair[3:0];
`ifdef MISALIGNED_SPLIT_EN
        state_d = split ? StAcc1 : StResp;
`else
        state_d = StResp;
`endif
      end
`ifdef MISALIGNED_SPLIT_EN
      StAcc1: begin
        bus.mem_addr = word_q + 1'b1;
        if (we_q) bus.mem_byteEnable = be_pair[7:4];
        else      lo_buf_d = bus.mem_dout;
        state_d = StResp;
      end
`endif
      StResp: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err;
        bus.resp_rdata = (we_q || err) ? 32'h0 : ext;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Reset drops any in-flight request: no write and no response in the reset cycle.
    if (rst) begin
      bus.mem_byteEnable = 4'b0000;
      bus.resp_valid     = 1'b0;
      bus.resp_err       = 1'b0;
      bus.resp_rdata     = 32'h0;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  logic clk;
  logic rst;
  logic mem_clr;
  int   n_checks;
  int   n_errors;

  load_store_unit_if #(.ADDRESS_WIDTH(4)) bus ();

  load_store_unit #(
    .ADDRESS_WIDTH(4),
    .DATA_WIDTH   (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first synchronous data memory, 16 words.
  logic [31:0] mem_q [16];
  logic [31:0] dout_q;
  assign bus.mem_dout = dout_q;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= 32'h0;
      dout_q <= 32'h0;
    end else begin
      if (|bus.mem_byteEnable)
        mem_q[bus.mem_addr] <= merge(mem_q[bus.mem_addr], bus.mem_din, bus.mem_byteEnable);
      dout_q <= merge(mem_q[bus.mem_addr], bus.mem_din, bus.mem_byteEnable);
    end
  end

  // Reference model: a flat 64-byte memory with wrap-around byte addressing.
  logic [7:0] ref_mem [64];

  task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic err,
                            output logic [31:0] rdata, output int lat,
                            output logic [3:0] be0, output logic [3:0] be1);
    int size, off, base, b;
    logic legal, misal;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    base  = int'(addr % 64);
    off   = base % 4;
    misal = (base % size) != 0;
`ifdef MISALIGNED_SPLIT_EN
    err = !legal;
`else
    err = !legal || misal;
`endif
    lat   = (!err && (off + size > 4)) ? 3 : 2;
    rdata = 32'h0;
    be0   = 4'b0000;
    be1   = 4'b0000;
    v     = 32'h0;
    if (!err) begin
      for (int i = 0; i < size; i++) begin
        b = (base + i) % 64;
        if (we) begin
          ref_mem[b] = wdata[8*i +: 8];
          if (off + i < 4) be0[off + i] = 1'b1;
          else             be1[off + i - 4] = 1'b1;
        end else begin
          v[8*i +: 8] = ref_mem[b];
        end
      end
      if (!we) begin
        case (f3)
          3'd0:    rdata = {{24{v[7]}}, v[7:0]};
          3'd1:    rdata = {{16{v[15]}}, v[15:0]};
          3'd4:    rdata = {24'h0, v[7:0]};
          3'd5:    rdata = {16'h0, v[15:0]};
          default: rdata = v;
        endcase
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Observations of the last transaction, and model predictions for it.
  logic        obs_err, mdl_err;
  logic [31:0] obs_rdata, mdl_rdata, obs_din0;
  int          obs_lat, mdl_lat;
  logic [3:0]  obs_be0, obs_be1, obs_a0, obs_a1, mdl_be0, mdl_be1;

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int n;
    ref_access(we, f3, addr, wdata, mdl_err, mdl_rdata, mdl_lat, mdl_be0, mdl_be1);
    obs_lat = 0; obs_err = 1'bx; obs_rdata = 32'hx;
    obs_be0 = 4'hx; obs_be1 = 4'hx; obs_a0 = 4'hx; obs_a1 = 4'hx; obs_din0 = 32'hx;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", 32'(bus.req_ready), 32'h1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 1) begin
        obs_a0 = bus.mem_addr; obs_be0 = bus.mem_byteEnable; obs_din0 = bus.mem_din;
      end
      if (k == 2) begin obs_a1 = bus.mem_addr; obs_be1 = bus.mem_byteEnable; end
      if (bus.resp_valid) begin
        obs_lat = k; obs_err = bus.resp_err; obs_rdata = bus.resp_rdata;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  be0;
    logic [3:0]  a0;
    logic        chk_din;
    logic [31:0] din0;
    logic [3:0]  a1;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic err,
                              input logic [31:0] rdata, input int lat, input logic [3:0] be0,
                              input logic [3:0] a0, input logic chk_din,
                              input logic [31:0] din0, input logic [3:0] a1);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.err = err; v.rdata = rdata;
    v.lat = lat; v.be0 = be0; v.a0 = a0; v.chk_din = chk_din; v.din0 = din0; v.a1 = a1;
    return v;
  endfunction

  localparam int NumVec = 18;
  vec_t vecs [NumVec];

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        t_we, q_ok;
    logic [2:0]  t_f3;
    logic [31:0] t_addr, t_wdata, t_rot;
    logic [63:0] t_pair;

    n_checks = 0; n_errors = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    rst = 1'b1; mem_clr = 1'b1;

    //                 we f3  addr    wdata         err rdata         lat be0  a0 cd din0 a1
    vecs[0]  = mk(1, 2, 'h04, 'h80017F00, 0, 'h0, 2, 4'hF, 1, 1, 'h80017F00, 0);
    vecs[1]  = mk(1, 2, 'h3C, 'h44332211, 0, 'h0, 2, 4'hF, 15, 1, 'h44332211, 0);
    vecs[2]  = mk(1, 2, 'h00, 'h88776655, 0, 'h0, 2, 4'hF, 0, 1, 'h88776655, 0);
    vecs[3]  = mk(1, 2, 'h08, 'hDEADBEEF, 0, 'h0, 2, 4'hF, 2, 1, 'hDEADBEEF, 0);
    vecs[4]  = mk(0, 2, 'h08, 'h0, 0, 'hDEADBEEF, 2, 4'h0, 2, 0, 'h0, 0);
    vecs[5]  = mk(0, 1, 'h06, 'h0, 0, 'hFFFF8001, 2, 4'h0, 1, 0, 'h0, 0);
    vecs[6]  = mk(0, 5, 'h06, 'h0, 0, 'h00008001, 2, 4'h0, 1, 0, 'h0, 0);
    vecs[7]  = mk(0, 1, 'h04, 'h0, 0, 'h00007F00, 2, 4'h0, 1, 0, 'h0, 0);
    vecs[8]  = mk(1, 0, 'h05, 'hA5, 0, 'h0, 2, 4'b0010, 1, 1, 'h0000A500, 0);
    vecs[9]  = mk(0, 0, 'h05, 'h0, 0, 'hFFFFFFA5, 2, 4'h0, 1, 0, 'h0, 0);
    vecs[10] = mk(0, 4, 'h05, 'h0, 0, 'h000000A5, 2, 4'h0, 1, 0, 'h0, 0);
    vecs[11] = mk(0, 3, 'h00, 'h0, 1, 'h0, 2, 4'h0, 0, 0, 'h0, 0);
    vecs[13] = mk(1, 5, 'h10, 'hFFFFFFFF, 1, 'h0, 2, 4'h0, 4, 0, 'h0, 0);
`ifdef MISALIGNED_SPLIT_EN
    vecs[12] = mk(0, 2, 'h3D, 'h0, 0, 'h55443322, 3, 4'h0, 15, 0, 'h0, 0);
    vecs[14] = mk(0, 1, 'h05, 'h0, 0, 'h000001A5, 2, 4'h0, 1, 0, 'h0, 0);
    vecs[15] = mk(1, 1, 'h0B, 'h1234, 0, 'h0, 3, 4'b1000, 2, 1, 'h34000012, 3);
    vecs[16] = mk(0, 2, 'h08, 'h0, 0, 'h34ADBEEF, 2, 4'h0, 2, 0, 'h0, 0);
    vecs[17] = mk(0, 2, 'h0C, 'h0, 0, 'h00000012, 2, 4'h0, 3, 0, 'h0, 0);
`else
    vecs[12] = mk(0, 2, 'h3D, 'h0, 1, 'h0, 2, 4'h0, 15, 0, 'h0, 0);
    vecs[14] = mk(0, 1, 'h05, 'h0, 1, 'h0, 2, 4'h0, 1, 0, 'h0, 0);
    vecs[15] = mk(1, 1, 'h0B, 'h1234, 1, 'h0, 2, 4'h0, 2, 0, 'h0, 0);
    vecs[16] = mk(0, 2, 'h08, 'h0, 0, 'hDEADBEEF, 2, 4'h0, 2, 0, 'h0, 0);
    vecs[17] = mk(0, 2, 'h0C, 'h0, 0, 'h00000000, 2, 4'h0, 3, 0, 'h0, 0);
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_din", bus.mem_din, 32'h0);
    chk("rst_mem_be", 32'(bus.mem_byteEnable), 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;

    // Directed table
    for (int i = 0; i < NumVec; i++) begin
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("v%0d_lat", i), 32'(obs_lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_err", i), 32'(obs_err), 32'(vecs[i].err));
      chk($sformatf("v%0d_rdata", i), obs_rdata, vecs[i].rdata);
      chk($sformatf("v%0d_be0", i), 32'(obs_be0), 32'(vecs[i].be0));
      chk($sformatf("v%0d_addr0", i), 32'(obs_a0), 32'(vecs[i].a0));
      if (vecs[i].chk_din) chk($sformatf("v%0d_din0", i), obs_din0, vecs[i].din0);
      if (vecs[i].lat == 3) chk($sformatf("v%0d_addr1", i), 32'(obs_a1), 32'(vecs[i].a1));
    end

    // Reset while a store is in flight (second access of a split store when enabled)
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h3E; bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
    chk("rstfly_be0", 32'(bus.mem_byteEnable), 32'hC);
    ref_mem[62] = 8'h0D;
    ref_mem[63] = 8'hF0;
`else
    chk("rstfly_be0", 32'(bus.mem_byteEnable), 32'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstfly_be_in_reset", 32'(bus.mem_byteEnable), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstfly_req_ready", 32'(bus.req_ready), 32'h1);
    q_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (bus.resp_valid) q_ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("rstfly_no_resp", 32'(q_ok), 32'h1);
    do_req(1'b0, 3'd2, 32'h00, 32'h0);
    chk("rstfly_word0_rdata", obs_rdata, mdl_rdata);
    chk("rstfly_word0_literal", obs_rdata, 32'h88776655);
    do_req(1'b0, 3'd2, 32'h3C, 32'h0);
    chk("rstfly_word15_rdata", obs_rdata, mdl_rdata);

    // Randomized traffic against the byte-level model
    for (int i = 0; i < 80; i++) begin
      t_we    = 1'($urandom_range(0, 1));
      t_f3    = 3'($urandom_range(0, 7));
      t_addr  = $urandom;
      t_wdata = $urandom;
      do_req(t_we, t_f3, t_addr, t_wdata);
      chk($sformatf("r%0d_lat", i), 32'(obs_lat), 32'(mdl_lat));
      chk($sformatf("r%0d_err", i), 32'(obs_err), 32'(mdl_err));
      chk($sformatf("r%0d_rdata", i), obs_rdata, mdl_rdata);
      chk($sformatf("r%0d_be0", i), 32'(obs_be0), 32'(mdl_be0));
      chk($sformatf("r%0d_addr0", i), 32'(obs_a0), 32'(t_addr[5:2]));
      if (t_we && !mdl_err) begin
        t_pair = {t_wdata, t_wdata} << (8 * t_addr[1:0]);
        t_rot  = t_pair[63:32];
        chk($sformatf("r%0d_din0", i), obs_din0, t_rot);
      end
      if (mdl_lat == 3) begin
        chk($sformatf("r%0d_addr1", i), 32'(obs_a1), 32'(4'(t_addr[5:2] + 4'd1)));
        if (t_we) chk($sformatf("r%0d_be1", i), 32'(obs_be1), 32'(mdl_be1));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
